// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: bundle of every mem_ctrl signal except clk/rst.
//   master : requester/environment side (IF unit, LSB, RAM/IO pins, rdy/flush)
//   slave  : mem_ctrl side
interface mem_ctrl_if #(parameter int ADDR_W = 32);
  logic              rdy;
  logic              jump_flag;
  logic              io_buffer_full;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              if_enable;
  logic [ADDR_W-1:0] if_addr;
  logic              if_success;
  logic [31:0]       if_rdata;
  logic              lsb_enable;
  logic              lsb_wr_tag;
  logic [2:0]        lsb_op_size;
  logic [ADDR_W-1:0] lsb_addr;
  logic [31:0]       lsb_wdata;
  logic              lsb_success;
  logic [31:0]       lsb_rdata;

  modport master (
    output rdy, jump_flag, io_buffer_full, mem_din,
           if_enable, if_addr,
           lsb_enable, lsb_wr_tag, lsb_op_size, lsb_addr, lsb_wdata,
    input  mem_dout, mem_a, mem_wr, if_success, if_rdata, lsb_success, lsb_rdata
  );

  modport slave (
    input  rdy, jump_flag, io_buffer_full, mem_din,
           if_enable, if_addr,
           lsb_enable, lsb_wr_tag, lsb_op_size, lsb_addr, lsb_wdata,
    output mem_dout, mem_a, mem_wr, if_success, if_rdata, lsb_success, lsb_rdata
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: sole owner of the 8-bit RAM/IO port. Arbitrates IF fetches and
// LSB loads/stores (LSB has fixed priority) and runs each grant as 1/2/4
// byte-serial accesses, returning one success pulse per request.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : mem_ctrl_if.slave (rdy, jump_flag, io_buffer_full, RAM pins,
//               IF request/response, LSB request/response)
// Build option: MEM_CTRL_IF_ABORT_EN -- when defined, jump_flag during an
// IF-owned read abandons it (back to IDLE, no if_success).
module mem_ctrl #(
  parameter logic [1:0] IO_HI  = 2'b11,
  parameter int         ADDR_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_LSB = 2'd2} owner_t;

  state_t            state;
  owner_t            owner;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        n;
  logic [2:0]        cnt;
  logic [31:0]       wdata;
  logic [31:0]       rbuf;

  logic [2:0]        lsb_n;
  logic              lsb_io;
  logic              stall;
  logic [1:0]        cap_idx;
  logic [1:0]        nxt_idx;
  logic [ADDR_W-1:0] nxt_a;
  logic [31:0]       rfinal;

  always_comb begin
    case (bus.lsb_op_size)
      3'b001:  lsb_n = 3'd1;
      3'b010:  lsb_n = 3'd2;
      default: lsb_n = 3'd4;
    endcase
  end

  assign lsb_io  = (bus.lsb_addr[17:16] == IO_HI);
  assign stall   = (addr[17:16] == IO_HI) && bus.io_buffer_full;
  // In READ, cnt counts edges since grant; the byte on mem_din at edge
  // E_{cnt+1} belongs to offset cnt-1 (one-cycle RAM read latency).
  assign cap_idx = cnt[1:0] - 2'd1;
  assign nxt_idx = cnt[1:0] + 2'd1;
  assign nxt_a   = addr + ADDR_W'(cnt) + ADDR_W'(1);

  // Word as it will look once the byte currently on mem_din is merged in.
  always_comb begin
    rfinal = rbuf;
    rfinal[{cap_idx, 3'b000} +: 8] = bus.mem_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      owner           <= OWN_NONE;
      addr            <= '0;
      n               <= '0;
      cnt             <= '0;
      wdata           <= '0;
      rbuf            <= '0;
      bus.mem_dout    <= '0;
      bus.mem_a       <= '0;
      bus.mem_wr      <= 1'b0;
      bus.if_success  <= 1'b0;
      bus.if_rdata    <= '0;
      bus.lsb_success <= 1'b0;
      bus.lsb_rdata   <= '0;
    end else if (bus.rdy) begin
      bus.if_success  <= 1'b0;
      bus.lsb_success <= 1'b0;
      case (state)
        IDLE: begin
          bus.mem_wr <= 1'b0;
          cnt        <= '0;
          rbuf       <= '0;
          if (bus.lsb_enable) begin
            owner     <= OWN_LSB;
            addr      <= bus.lsb_addr;
            n         <= lsb_n;
            wdata     <= bus.lsb_wdata;
            bus.mem_a <= bus.lsb_addr;
            if (bus.lsb_wr_tag) begin
              state        <= WRITE;
              bus.mem_dout <= bus.lsb_wdata[7:0];
              bus.mem_wr   <= !(lsb_io && bus.io_buffer_full);
            end else begin
              state <= READ;
            end
          end else if (bus.if_enable && !bus.jump_flag) begin
            owner     <= OWN_IF;
            addr      <= bus.if_addr;
            n         <= 3'd4;
            bus.mem_a <= bus.if_addr;
            state     <= READ;
          end
        end
        READ: begin
`ifdef MEM_CTRL_IF_ABORT_EN
          if (owner == OWN_IF && bus.jump_flag) begin
            bus.mem_wr <= 1'b0;
            cnt        <= '0;
            state      <= IDLE;
          end else
`endif
          begin
            if (cnt + 3'd1 < n)
              bus.mem_a <= nxt_a;
            if (cnt == n) begin
              state <= DONE;
              if (owner == OWN_IF) begin
                bus.if_rdata   <= rfinal;
                bus.if_success <= 1'b1;
              end else begin
                bus.lsb_rdata   <= rfinal;
                bus.lsb_success <= 1'b1;
              end
            end else begin
              if (cnt != 3'd0)
                rbuf[{cap_idx, 3'b000} +: 8] <= bus.mem_din;
              cnt <= cnt + 3'd1;
            end
          end
        end
        WRITE: begin
          if (bus.mem_wr) begin
            // The byte driven last cycle commits at this edge.
            if (cnt + 3'd1 == n) begin
              bus.mem_wr      <= 1'b0;
              bus.lsb_success <= 1'b1;
              state           <= DONE;
            end else begin
              cnt          <= cnt + 3'd1;
              bus.mem_a    <= nxt_a;
              bus.mem_dout <= wdata[{nxt_idx, 3'b000} +: 8];
              bus.mem_wr   <= !stall;
            end
          end else begin
            // IO stall: address/data already on the pins, just wait.
            bus.mem_wr <= !stall;
          end
        end
        DONE: begin
          // Requester's enable is still high here, so no grant this cycle.
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl. A byte-array RAM model sits on
// the pins; a reference byte array predicts load data. Requests push their
// expected result into per-owner queues and a negedge monitor pops/compares
// on every success pulse. Directed cases plus a randomized request mix.
`timescale 1ns/1ps
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_W(32)) bus();
  mem_ctrl #(.IO_HI(2'b11), .ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct { bit st; logic [31:0] d; } exp_t;
  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
  exp_t if_q[$];
  exp_t lsb_q[$];
  wr_t  wlog[$];
  exp_t me;

  logic [7:0] ram  [0:262143];
  logic [7:0] refm [0:262143];
  bit ram_ready = 1'b0;

  function automatic int idx(input logic [31:0] a);
    return int'(a[17:0]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RAM device: one-cycle read latency, frozen together with the system by rdy.
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 262144; i++) ram[i] = refm[i];
      ram_ready = 1'b1;
    end
    if (bus.rdy) begin
      bus.mem_din <= ram[idx(bus.mem_a)];
      if (bus.mem_wr) begin
        ram[idx(bus.mem_a)] = bus.mem_dout;
        wlog.push_back('{bus.mem_a, bus.mem_dout});
      end
    end
  end

  // Monitor: every success pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && bus.rdy) begin
      if (bus.if_success) begin
        checks++;
        if (if_q.size() == 0) begin
          errors++;
          $display("FAIL if_success_unexpected: got pulse expected none");
        end else begin
          me = if_q.pop_front();
          chk("if_rdata", bus.if_rdata, me.d);
        end
      end
      if (bus.lsb_success) begin
        checks++;
        if (lsb_q.size() == 0) begin
          errors++;
          $display("FAIL lsb_success_unexpected: got pulse expected none");
        end else begin
          me = lsb_q.pop_front();
          if (!me.st) chk("lsb_rdata", bus.lsb_rdata, me.d);
        end
      end
    end
  end

  // Issue one request with the controller idle and measure grant->success.
  // jump_at: -1 none, 0 asserted with the request, k>0 asserted after edge k.
  task automatic req(input bit is_if, input bit wr, input int nb, input logic [31:0] a,
                     input logic [31:0] wd, input int stall, input int rdy_at,
                     input int jump_at, input string tag);
    exp_t e;
    int n, k, lat;
    bit got;
    logic [31:0] d;
    n = is_if ? 4 : nb;
    d = '0;
    for (int i = 0; i < n; i++) begin
      if (wr) refm[idx(a + i)] = wd[8*i +: 8];
      else    d[8*i +: 8] = refm[idx(a + i)];
    end
    e.st = wr;
    e.d  = d;
    if (is_if) if_q.push_back(e); else lsb_q.push_back(e);
    lat = wr ? n + stall : n + 1;
    if (rdy_at > 0) lat += 2;
    if (is_if && jump_at == 0) lat += 1;
    @(negedge clk);
    if (is_if) begin
      bus.if_enable = 1'b1;
      bus.if_addr   = a;
    end else begin
      bus.lsb_enable  = 1'b1;
      bus.lsb_wr_tag  = wr;
      bus.lsb_op_size = (nb == 1) ? 3'b001 : (nb == 2) ? 3'b010 : 3'b100;
      bus.lsb_addr    = a;
      bus.lsb_wdata   = wd;
    end
    bus.io_buffer_full = (stall > 0);
    if (jump_at == 0) bus.jump_flag = 1'b1;
    k = 0;
    got = 1'b0;
    while (!got && k < 80) begin
      @(posedge clk); #1;
      k++;
      if (stall > 0 && k == stall) bus.io_buffer_full = 1'b0;
      if (rdy_at > 0 && k == rdy_at) bus.rdy = 1'b0;
      if (rdy_at > 0 && k == rdy_at + 2) bus.rdy = 1'b1;
      if (jump_at > 0 && k == jump_at) bus.jump_flag = 1'b1;
      if (jump_at >= 0 && k == jump_at + 1) bus.jump_flag = 1'b0;
      got = is_if ? bus.if_success : bus.lsb_success;
    end
    chk({tag, "_done"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(k - 1), 32'(lat));
    bus.if_enable      = 1'b0;
    bus.lsb_enable     = 1'b0;
    bus.io_buffer_full = 1'b0;
    bus.jump_flag      = 1'b0;
    bus.rdy            = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic t3_contention();
    exp_t e;
    int k, lt, it;
    e.st = 1'b0; e.d = {24'b0, refm[7]};
    lsb_q.push_back(e);
    e.d = {refm[idx(32'h100 + 3)], refm[idx(32'h100 + 2)], refm[idx(32'h100 + 1)], refm[idx(32'h100)]};
    if_q.push_back(e);
    @(negedge clk);
    bus.lsb_enable = 1'b1; bus.lsb_wr_tag = 1'b0; bus.lsb_op_size = 3'b001; bus.lsb_addr = 32'h7;
    bus.if_enable = 1'b1; bus.if_addr = 32'h100;
    k = 0; lt = 0; it = 0;
    while ((lt == 0 || it == 0) && k < 60) begin
      @(posedge clk); #1;
      k++;
      if (bus.lsb_success && lt == 0) begin lt = k; bus.lsb_enable = 1'b0; end
      if (bus.if_success && it == 0) begin it = k; bus.if_enable = 1'b0; end
    end
    chk("t3_lsb_latency", 32'(lt - 1), 32'd2);
    chk("t3_lsb_first", 32'(lt > 0 && lt < it), 32'd1);
    chk("t3_if_wait_bound", 32'(it > 0 && (it - lt) <= 8), 32'd1);
    bus.lsb_enable = 1'b0; bus.if_enable = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic t5_if_jump();
    exp_t e;
    int k;
    bit got;
`ifndef MEM_CTRL_IF_ABORT_EN
    e.st = 1'b0;
    e.d  = {refm[idx(32'h107)], refm[idx(32'h106)], refm[idx(32'h105)], refm[idx(32'h104)]};
    if_q.push_back(e);
`endif
    @(negedge clk);
    bus.if_enable = 1'b1; bus.if_addr = 32'h104;
    k = 0; got = 1'b0;
    while (!got && k < 12) begin
      @(posedge clk); #1;
      k++;
      if (k == 3) bus.jump_flag = 1'b1;
      if (k == 4) begin
        bus.jump_flag = 1'b0;
`ifdef MEM_CTRL_IF_ABORT_EN
        bus.if_enable = 1'b0;
`endif
      end
      got = bus.if_success;
    end
`ifdef MEM_CTRL_IF_ABORT_EN
    chk("t5_if_aborted", 32'(got), 32'd0);
    chk("t5_abort_mem_wr", 32'(bus.mem_wr), 32'd0);
`else
    chk("t5_if_done", 32'(got), 32'd1);
    chk("t5_if_latency", 32'(k - 1), 32'd5);
`endif
    bus.if_enable = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic t6_reset_mid_store();
    refm[idx(32'h300)] = 8'h44;
    refm[idx(32'h301)] = 8'h33;
    @(negedge clk);
    bus.lsb_enable = 1'b1; bus.lsb_wr_tag = 1'b1; bus.lsb_op_size = 3'b100;
    bus.lsb_addr = 32'h300; bus.lsb_wdata = 32'h11223344;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    chk("t6_rst_mem_a", bus.mem_a, 32'd0);
    chk("t6_rst_mem_dout", 32'(bus.mem_dout), 32'd0);
    chk("t6_rst_lsb_success", 32'(bus.lsb_success), 32'd0);
    bus.lsb_enable = 1'b0;
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic rand_phase();
    int r, nb, st, ra;
    logic [31:0] a;
    for (int it = 0; it < 50; it++) begin
      r  = $urandom_range(0, 3);
      case ($urandom_range(0, 2))
        0: nb = 1;
        1: nb = 2;
        default: nb = 4;
      endcase
      a  = 32'h100 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFD;
      ra = ($urandom_range(0, 3) == 0) ? 1 : 0;
      case (r)
        0: req(1'b1, 1'b0, 4, a, 32'h0, 0, ra, -1, "rnd_if");
        1: req(1'b0, 1'b0, nb, a, 32'h0, 0, ra, -1, "rnd_ld");
        2: req(1'b0, 1'b1, nb, a, $urandom, 0, 0, -1, "rnd_st");
        default: begin
          st = $urandom_range(0, 3);
          req(1'b0, 1'b1, nb, 32'h0003_0000 + 32'($urandom_range(0, 15)), $urandom, st, 0, -1, "rnd_io");
        end
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int base, mism;
    logic [7:0] t2b [4];
    bus.rdy = 1'b1; bus.jump_flag = 1'b0; bus.io_buffer_full = 1'b0;
    bus.if_enable = 1'b0; bus.if_addr = '0;
    bus.lsb_enable = 1'b0; bus.lsb_wr_tag = 1'b0; bus.lsb_op_size = 3'b001;
    bus.lsb_addr = '0; bus.lsb_wdata = '0;
    for (int i = 0; i < 262144; i++) refm[i] = 8'($urandom);
    refm[32'h100] = 8'h13; refm[32'h101] = 8'h05; refm[32'h102] = 8'h00; refm[32'h103] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    chk("rst_mem_a", bus.mem_a, 32'd0);
    chk("rst_mem_dout", 32'(bus.mem_dout), 32'd0);
    chk("rst_if_success", 32'(bus.if_success), 32'd0);
    chk("rst_lsb_success", 32'(bus.lsb_success), 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'd0);
    chk("rst_lsb_rdata", bus.lsb_rdata, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // T1: IF word fetch, no writes on the bus.
    base = wlog.size();
    req(1'b1, 1'b0, 4, 32'h100, 32'h0, 0, 0, -1, "t1");
    chk("t1_word", bus.if_rdata, 32'h0000_0513);
    chk("t1_no_write", 32'(wlog.size() - base), 32'd0);

    // T2: sw then lw at 0x200.
    t2b[0] = 8'hEF; t2b[1] = 8'hBE; t2b[2] = 8'hAD; t2b[3] = 8'hDE;
    base = wlog.size();
    req(1'b0, 1'b1, 4, 32'h200, 32'hDEADBEEF, 0, 0, -1, "t2_sw");
    chk("t2_write_count", 32'(wlog.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < wlog.size()) begin
        chk("t2_write_addr", wlog[base + i].a, 32'h200 + 32'(i));
        chk("t2_write_data", 32'(wlog[base + i].d), 32'(t2b[i]));
      end
    end
    req(1'b0, 1'b0, 4, 32'h200, 32'h0, 0, 0, -1, "t2_lw");
    chk("t2_lw_data", bus.lsb_rdata, 32'hDEADBEEF);

    // T3: simultaneous IF and LSB lb.
    t3_contention();

    // T4: IO byte store with the UART buffer full for 3 cycles.
    base = wlog.size();
    req(1'b0, 1'b1, 1, 32'h0003_0000, 32'h41, 3, 0, -1, "t4");
    chk("t4_write_count", 32'(wlog.size() - base), 32'd1);
    if (base < wlog.size()) begin
      chk("t4_write_addr", wlog[base].a, 32'h0003_0000);
      chk("t4_write_data", 32'(wlog[base].d), 32'h41);
    end

    // T5: flush during an IF read, during an LSB load, and while idle.
    t5_if_jump();
    req(1'b0, 1'b0, 4, 32'h120, 32'h0, 0, 0, 3, "t5_lsb_lw");
    req(1'b1, 1'b0, 4, 32'h124, 32'h0, 0, 0, 0, "t5_idle_jump");

    // T6: reset mid store, rdy pause mid read.
    t6_reset_mid_store();
    req(1'b1, 1'b0, 4, 32'h100, 32'h0, 0, 2, -1, "t6_rdy");
    req(1'b0, 1'b0, 2, 32'h300, 32'h0, 0, 0, -1, "t6_after_rst");

    // Address wrap across 2^32.
    req(1'b0, 1'b1, 2, 32'hFFFF_FFFF, 32'h0000_A55A, 0, 0, -1, "wrap_sh");
    req(1'b0, 1'b0, 2, 32'hFFFF_FFFF, 32'h0, 0, 0, -1, "wrap_lh");
    chk("wrap_data", bus.lsb_rdata, 32'h0000_A55A);

    rand_phase();

    repeat (4) @(posedge clk);
    #1;
    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("lsb_q_drained", 32'(lsb_q.size()), 32'd0);
    mism = 0;
    for (int i = 0; i < 262144; i++) if (ram[i] !== refm[i]) mism++;
    chk("ram_contents", 32'(mism), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
